// File: rtl/cdb_lane_arbiter.sv
// Merges three execution-unit result streams (ALU, MUL, DIV) onto one registered CDB lane.
// Each source has a small holding FIFO; a round-robin picker pops at most one head per cycle.
module cdb_lane_arbiter #(
  parameter int ROB_BITS = 4,
  parameter int DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                src0_valid,
  input  logic [ROB_BITS:0]   src0_ROBEN,
  input  logic [31:0]         src0_Write_Data,
  input  logic                src0_EXCEPTION,
  output logic                src0_ready,
  input  logic                src1_valid,
  input  logic [ROB_BITS:0]   src1_ROBEN,
  input  logic [31:0]         src1_Write_Data,
  input  logic                src1_EXCEPTION,
  output logic                src1_ready,
  input  logic                src2_valid,
  input  logic [ROB_BITS:0]   src2_ROBEN,
  input  logic [31:0]         src2_Write_Data,
  input  logic                src2_EXCEPTION,
  output logic                src2_ready,
  output logic [ROB_BITS:0]   out_ROBEN,
  output logic [31:0]         out_Write_Data,
  output logic                out_EXCEPTION
);
  localparam int RW = ROB_BITS + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Handshake: a result transfers on a rising edge where valid && ready (and ROBEN != 0,
  // flush low). ready depends only on the registered count; valid while !ready is dropped,
  // so a source must keep valid and its payload stable until it sees ready.
  logic [2:0]    in_valid;
  logic [RW-1:0] in_roben [3];
  logic [31:0]   in_data  [3];
  logic [2:0]    in_exc;

  assign in_valid    = {src2_valid, src1_valid, src0_valid};
  assign in_roben[0] = src0_ROBEN;
  assign in_roben[1] = src1_ROBEN;
  assign in_roben[2] = src2_ROBEN;
  assign in_data[0]  = src0_Write_Data;
  assign in_data[1]  = src1_Write_Data;
  assign in_data[2]  = src2_Write_Data;
  assign in_exc      = {src2_EXCEPTION, src1_EXCEPTION, src0_EXCEPTION};

  logic [RW-1:0]    roben_mem_q [3][DEPTH];
  logic [RW-1:0]    roben_mem_d [3][DEPTH];
  logic [31:0]      data_mem_q  [3][DEPTH];
  logic [31:0]      data_mem_d  [3][DEPTH];
  logic [DEPTH-1:0] exc_mem_q   [3];
  logic [DEPTH-1:0] exc_mem_d   [3];
  logic [PW-1:0]    wptr_q [3], wptr_d [3];
  logic [PW-1:0]    rptr_q [3], rptr_d [3];
  logic [CW-1:0]    cnt_q  [3], cnt_d  [3];
  logic [1:0]       last_grant_q, last_grant_d;
  logic [RW-1:0]    out_roben_q, out_roben_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_exc_q, out_exc_d;

  logic [2:0] ready;
  logic [2:0] push;
  logic [2:0] pop;
  logic       grant_vld;
  logic [1:0] grant_sel;
  logic [2:0] cand;

  always_comb begin
    roben_mem_d  = roben_mem_q;
    data_mem_d   = data_mem_q;
    exc_mem_d    = exc_mem_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    out_roben_d  = '0;
    out_data_d   = '0;
    out_exc_d    = 1'b0;
    grant_vld    = 1'b0;
    grant_sel    = 2'd0;
    cand         = '0;
    ready        = '0;
    push         = '0;
    pop          = '0;

    // Round-robin: first non-empty queue after the last winner, wrapping mod 3.
    for (int off = 1; off <= 3; off++) begin
      cand = {1'b0, last_grant_q} + 3'(off);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!grant_vld && cnt_q[cand[1:0]] != '0) begin
        grant_vld = 1'b1;
        grant_sel = cand[1:0];
      end
    end

    for (int k = 0; k < 3; k++) begin
      ready[k] = cnt_q[k] < CW'(DEPTH);
      push[k]  = in_valid[k] && ready[k] && (in_roben[k] != '0) && !flush;
      pop[k]   = grant_vld && (grant_sel == 2'(k)) && !flush;
      if (push[k]) begin
        roben_mem_d[k][wptr_q[k]] = in_roben[k];
        data_mem_d[k][wptr_q[k]]  = in_data[k];
        exc_mem_d[k][wptr_q[k]]   = in_exc[k];
        wptr_d[k]                 = wptr_q[k] + PW'(1);
      end
      if (pop[k]) rptr_d[k] = rptr_q[k] + PW'(1);
      if (push[k] && !pop[k])      cnt_d[k] = cnt_q[k] + CW'(1);
      else if (!push[k] && pop[k]) cnt_d[k] = cnt_q[k] - CW'(1);
    end

    if (flush) begin
      for (int k = 0; k < 3; k++) begin
        wptr_d[k] = '0;
        rptr_d[k] = '0;
        cnt_d[k]  = '0;
      end
      last_grant_d = 2'd2;
    end else if (grant_vld) begin
      out_roben_d  = roben_mem_q[grant_sel][rptr_q[grant_sel]];
      out_data_d   = data_mem_q[grant_sel][rptr_q[grant_sel]];
      out_exc_d    = exc_mem_q[grant_sel][rptr_q[grant_sel]];
      last_grant_d = grant_sel;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        for (int e = 0; e < DEPTH; e++) begin
          roben_mem_q[k][e] <= '0;
          data_mem_q[k][e]  <= '0;
        end
        exc_mem_q[k] <= '0;
        wptr_q[k]    <= '0;
        rptr_q[k]    <= '0;
        cnt_q[k]     <= '0;
      end
      last_grant_q <= 2'd2;
      out_roben_q  <= '0;
      out_data_q   <= '0;
      out_exc_q    <= 1'b0;
    end else begin
      roben_mem_q  <= roben_mem_d;
      data_mem_q   <= data_mem_d;
      exc_mem_q    <= exc_mem_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      out_roben_q  <= out_roben_d;
      out_data_q   <= out_data_d;
      out_exc_q    <= out_exc_d;
    end
  end

  assign src0_ready     = ready[0];
  assign src1_ready     = ready[1];
  assign src2_ready     = ready[2];
  assign out_ROBEN      = out_roben_q;
  assign out_Write_Data = out_data_q;
  assign out_EXCEPTION  = out_exc_q;
endmodule

// File: tb/tb_cdb_lane_arbiter.sv
// Directed bench for cdb_lane_arbiter: per-scenario tasks with hand-computed broadcast sequences.
module tb_cdb_lane_arbiter;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic [2:0]    v = '0;
  logic [RW-1:0] rb [3];
  logic [31:0]   wd [3];
  logic [2:0]    ex = '0;
  wire  [2:0]    rdy;
  logic [RW-1:0] out_roben;
  logic [31:0]   out_data;
  logic          out_exc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cdb_lane_arbiter #(.ROB_BITS(4), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .src0_valid(v[0]), .src0_ROBEN(rb[0]), .src0_Write_Data(wd[0]),
    .src0_EXCEPTION(ex[0]), .src0_ready(rdy[0]),
    .src1_valid(v[1]), .src1_ROBEN(rb[1]), .src1_Write_Data(wd[1]),
    .src1_EXCEPTION(ex[1]), .src1_ready(rdy[1]),
    .src2_valid(v[2]), .src2_ROBEN(rb[2]), .src2_Write_Data(wd[2]),
    .src2_EXCEPTION(ex[2]), .src2_ready(rdy[2]),
    .out_ROBEN(out_roben), .out_Write_Data(out_data), .out_EXCEPTION(out_exc)
  );

  // Payload attached to a tag by the driver; tag 0 means an empty lane, so data 0.
  function automatic logic [31:0] tag_data(input logic [RW-1:0] r);
    return (r == '0) ? 32'h0 : (32'hC0DE_0000 | 32'(r));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    v = '0;
    ex = '0;
    for (int k = 0; k < 3; k++) begin
      rb[k] = '0;
      wd[k] = '0;
    end
  endtask

  task automatic drive(input int k, input logic [RW-1:0] r, input logic e);
    v[k]  = 1'b1;
    rb[k] = r;
    wd[k] = tag_data(r);
    ex[k] = e;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    #12;
    n_checks++;
    if (out_roben !== '0 || out_data !== 32'h0 || out_exc !== 1'b0) begin
      $display("FAIL reset_out: got %0d/%h/%b expected 0/00000000/0", out_roben, out_data, out_exc);
      n_fail++;
    end
    n_checks++;
    if (rdy !== 3'b111) begin
      $display("FAIL reset_ready: got %b expected 111", rdy);
      n_fail++;
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (out_roben !== '0) begin
      $display("FAIL reset_first_edge: got %0d expected 0", out_roben);
      n_fail++;
    end
  endtask

  task automatic test_single_push();
    idle();
    drive(1, 5'd5, 1'b0);
    wd[1] = 32'hDEADBEEF;
    tick();
    idle();
    n_checks++;
    if (out_roben !== '0) begin
      $display("FAIL single_push_e1: got %0d expected 0", out_roben);
      n_fail++;
    end
    tick();
    n_checks++;
    if (out_roben !== 5'd5 || out_data !== 32'hDEADBEEF || out_exc !== 1'b0) begin
      $display("FAIL single_push_e2: got %0d/%h/%b expected 5/deadbeef/0", out_roben, out_data, out_exc);
      n_fail++;
    end
    tick();
    n_checks++;
    if (out_roben !== '0 || out_data !== 32'h0 || out_exc !== 1'b0) begin
      $display("FAIL single_push_e3: got %0d/%h/%b expected 0/00000000/0", out_roben, out_data, out_exc);
      n_fail++;
    end
  endtask

  task automatic test_contention();
    logic [RW-1:0] exp_r [5];
    logic          exp_e [5];
    exp_r = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd0};
    exp_e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_flush();
    drive(0, 5'd1, 1'b0);
    drive(1, 5'd2, 1'b0);
    drive(2, 5'd3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      idle();
      n_checks++;
      if (out_roben !== exp_r[i] || out_data !== tag_data(exp_r[i]) || out_exc !== exp_e[i]) begin
        $display("FAIL contention_e%0d: got %0d/%h/%b expected %0d/%h/%b", i + 1,
                 out_roben, out_data, out_exc, exp_r[i], tag_data(exp_r[i]), exp_e[i]);
        n_fail++;
      end
    end
    // With last_grant at 2 the search starts at src0, so src1 beats src2.
    drive(1, 5'd11, 1'b0);
    drive(2, 5'd12, 1'b0);
    tick();
    idle();
    tick();
    n_checks++;
    if (out_roben !== 5'd11) begin
      $display("FAIL contention_last_grant: got %0d expected 11", out_roben);
      n_fail++;
    end
    tick();
    n_checks++;
    if (out_roben !== 5'd12) begin
      $display("FAIL contention_second: got %0d expected 12", out_roben);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_fairness();
    int d0 [6];
    int d2 [6];
    int exp_r [6];
    d0    = '{8, 9, 10, 0, 0, 0};
    d2    = '{0, 20, 0, 0, 0, 0};
    exp_r = '{0, 8, 20, 9, 10, 0};
    do_flush();
    for (int i = 0; i < 6; i++) begin
      idle();
      if (d0[i] != 0) drive(0, RW'(d0[i]), 1'b0);
      if (d2[i] != 0) drive(2, RW'(d2[i]), 1'b0);
      tick();
      n_checks++;
      if (out_roben !== RW'(exp_r[i]) || out_data !== tag_data(RW'(exp_r[i]))) begin
        $display("FAIL fairness_e%0d: got %0d/%h expected %0d", i + 1, out_roben, out_data, exp_r[i]);
        n_fail++;
      end
      if (i == 2) begin
        n_checks++;
        if (rdy[0] !== 1'b0) begin
          $display("FAIL fairness_src0_full: got ready %b expected 0", rdy[0]);
          n_fail++;
        end
      end
    end
    idle();
  endtask

  task automatic test_backpressure();
    int d0 [8];
    int d1 [8];
    int d2 [8];
    int exp_r [8];
    d0    = '{4, 5, 0, 0, 0, 0, 0, 0};
    d1    = '{6, 7, 15, 0, 0, 0, 0, 0};
    d2    = '{8, 9, 0, 0, 0, 0, 0, 0};
    exp_r = '{0, 4, 6, 8, 5, 7, 9, 0};
    do_flush();
    for (int i = 0; i < 8; i++) begin
      idle();
      if (d0[i] != 0) drive(0, RW'(d0[i]), 1'b0);
      if (d1[i] != 0) drive(1, RW'(d1[i]), 1'b0);
      if (d2[i] != 0) drive(2, RW'(d2[i]), 1'b0);
      tick();
      n_checks++;
      if (out_roben !== RW'(exp_r[i]) || out_data !== tag_data(RW'(exp_r[i]))) begin
        $display("FAIL backpressure_e%0d: got %0d/%h expected %0d", i + 1, out_roben, out_data, exp_r[i]);
        n_fail++;
      end
      if (i == 1) begin
        n_checks++;
        if (rdy !== 3'b001) begin
          $display("FAIL backpressure_full_ready: got %b expected 001", rdy);
          n_fail++;
        end
      end
      if (i == 2) begin
        n_checks++;
        if (rdy[1] !== 1'b1) begin
          $display("FAIL backpressure_ready_after_pop: got %b expected 1", rdy[1]);
          n_fail++;
        end
      end
    end
    idle();
  endtask

  task automatic test_same_queue();
    int d0 [5];
    int exp_r [5];
    d0    = '{1, 2, 3, 0, 0};
    exp_r = '{0, 1, 2, 3, 0};
    do_flush();
    for (int i = 0; i < 5; i++) begin
      idle();
      if (d0[i] != 0) drive(0, RW'(d0[i]), 1'b0);
      tick();
      n_checks++;
      if (out_roben !== RW'(exp_r[i]) || rdy[0] !== 1'b1) begin
        $display("FAIL same_queue_e%0d: got %0d ready %b expected %0d ready 1", i + 1,
                 out_roben, rdy[0], exp_r[i]);
        n_fail++;
      end
    end
    idle();
  endtask

  task automatic test_flush();
    int f [9];
    int d0 [9];
    int d1 [9];
    int d2 [9];
    int exp_r [9];
    f     = '{0, 0, 1, 1, 0, 0, 0, 0, 0};
    d0    = '{1, 4, 12, 0, 0, 22, 0, 0, 0};
    d1    = '{2, 5, 0, 0, 0, 23, 0, 0, 0};
    d2    = '{3, 6, 0, 0, 0, 0, 0, 0, 0};
    exp_r = '{0, 1, 0, 0, 0, 0, 22, 23, 0};
    do_flush();
    for (int i = 0; i < 9; i++) begin
      idle();
      flush = (f[i] != 0);
      if (d0[i] != 0) drive(0, RW'(d0[i]), 1'b0);
      if (d1[i] != 0) drive(1, RW'(d1[i]), 1'b0);
      if (d2[i] != 0) drive(2, RW'(d2[i]), 1'b0);
      tick();
      n_checks++;
      if (out_roben !== RW'(exp_r[i]) || out_data !== tag_data(RW'(exp_r[i]))) begin
        $display("FAIL flush_e%0d: got %0d/%h expected %0d", i + 1, out_roben, out_data, exp_r[i]);
        n_fail++;
      end
      if (i == 2) begin
        n_checks++;
        if (rdy !== 3'b111) begin
          $display("FAIL flush_ready: got %b expected 111", rdy);
          n_fail++;
        end
      end
    end
    flush = 1'b0;
    idle();
  endtask

  task automatic test_roben_zero();
    idle();
    drive(0, 5'd0, 1'b1);
    drive(1, 5'd0, 1'b0);
    drive(2, 5'd0, 1'b0);
    tick();
    idle();
    n_checks++;
    if (rdy !== 3'b111) begin
      $display("FAIL roben_zero_ready: got %b expected 111", rdy);
      n_fail++;
    end
    tick();
    n_checks++;
    if (out_roben !== '0 || out_data !== 32'h0 || out_exc !== 1'b0) begin
      $display("FAIL roben_zero_out: got %0d/%h/%b expected 0/00000000/0", out_roben, out_data, out_exc);
      n_fail++;
    end
  endtask

  task automatic test_async_reset();
    do_flush();
    drive(0, 5'd1, 1'b0);
    drive(1, 5'd2, 1'b0);
    drive(2, 5'd3, 1'b0);
    tick();
    idle();
    tick();
    n_checks++;
    if (out_roben !== 5'd1) begin
      $display("FAIL async_reset_pre: got %0d expected 1", out_roben);
      n_fail++;
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_roben !== '0 || out_data !== 32'h0 || out_exc !== 1'b0 || rdy !== 3'b111) begin
      $display("FAIL async_reset_immediate: got %0d/%h/%b ready %b expected 0/00000000/0 ready 111",
               out_roben, out_data, out_exc, rdy);
      n_fail++;
    end
    #2;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (out_roben !== '0) begin
        $display("FAIL async_reset_idle_e%0d: got %0d expected 0", i + 1, out_roben);
        n_fail++;
      end
    end
    drive(1, 5'd7, 1'b0);
    drive(2, 5'd8, 1'b0);
    tick();
    idle();
    tick();
    n_checks++;
    if (out_roben !== 5'd7) begin
      $display("FAIL async_reset_last_grant: got %0d expected 7", out_roben);
      n_fail++;
    end
    tick();
    tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_single_push();
    test_contention();
    test_fairness();
    test_backpressure();
    test_same_queue();
    test_flush();
    test_roben_zero();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cdb_lane_arbiter.md
CDB_LANE_ARBITER -- requirements
Module: cdb_lane_arbiter

Interface
REQ-001 Parameter ROB_BITS, default 4, ROBEN width is ROB_BITS+1; ROBEN value 0 means "no broadcast".
REQ-002 Parameter DEPTH, default 2, entries per source holding queue; power of two, >= 2.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  synchronous squash of all held results (mispredict/exception recovery).
REQ-006 srcK_valid  input  1  result offered by source K, K = 0..2 (ALU, MUL, DIV).
REQ-007 srcK_ROBEN  input  ROB_BITS+1  destination ROB entry of the offered result.
REQ-008 srcK_Write_Data  input  32  result value.
REQ-009 srcK_EXCEPTION  input  1  exception flag of the result.
REQ-010 srcK_ready  output  1  source K queue can accept a result this cycle.
REQ-011 out_ROBEN  output  ROB_BITS+1  registered CDB lane tag.
REQ-012 out_Write_Data  output  32  registered CDB lane data.
REQ-013 out_EXCEPTION  output  1  registered CDB lane exception flag.

Function
REQ-014 Each source owns a FIFO of DEPTH entries {ROBEN, data, exception}, with read/write pointers and a count.
REQ-015 srcK_ready = (countK < DEPTH); derived from registered count only, with no combinational path from any input.
REQ-016 Push on an edge where srcK_valid && srcK_ready && srcK_ROBEN != 0 && !flush.
REQ-017 A valid result with ROBEN == 0 is discarded and not queued.
REQ-018 Valid while not ready is dropped; sources hold valid until ready and do not rely on the arbiter to retain the result.
REQ-019 Each cycle the arbiter selects one non-empty queue by round-robin: search starts at (last_grant + 1) mod 3 and proceeds cyclically.
REQ-020 Selected queue pops; its head is registered onto out_* at the same edge; last_grant updates to the selected source.
REQ-021 No queue non-empty: out_ROBEN = 0, out_Write_Data = 0, out_EXCEPTION = 0 at the next edge; last_grant unchanged.
REQ-022 Exactly one broadcast per cycle maximum; at most one pop per cycle overall.
REQ-023 Latency: a result pushed at edge E appears on out_* at edge E+1 at the earliest, i.e. when its queue was empty and it wins arbitration.
REQ-024 Same-queue push and pop on one edge: both occur, count unchanged, FIFO order preserved.
REQ-025 A full queue that pops on an edge still shows ready = 0 during that cycle, per REQ-015.
REQ-026 Pointers wrap modulo DEPTH; count ranges 0..DEPTH and never over- or underflows.
REQ-027 Per-source order is strictly FIFO; no ordering guarantee holds across sources.
REQ-028 flush, on the next edge: clears all counts and pointers, forces out_* to 0, and sets last_grant = 2; pushes and pops in the flush cycle are discarded.
REQ-029 A flush asserted on consecutive cycles holds this state; no result is broadcast while flush = 1.

Reset
REQ-030 rst = 0 immediately forces: all queues empty, last_grant = 2, out_ROBEN = 0, out_Write_Data = 0, out_EXCEPTION = 0.
REQ-031 During reset, srcK_ready = 1 for all K, since counts are 0.
REQ-032 Reset asserted mid-operation discards all held results with no partial broadcast; the first edge after release behaves as idle.

Verification
REQ-033 Single push: src1 pushes ROBEN=5, data=0xDEADBEEF, exc=0 at edge 1 -> out_* = {5, 0xDEADBEEF, 0} after edge 2, zeros after edge 3.
REQ-034 Contention: all three sources push at edge 1 (ROBEN 1, 2, 3) -> out_ROBEN = 1, 2, 3 after edges 2, 3, 4; last_grant ends at 2.
REQ-035 Fairness: src0 pushes every cycle, src2 pushes once -> src2's result broadcast within 2 cycles of becoming head.
REQ-036 Full/backpressure: MUL queue receives 2 pushes with no pops (src0 and src2 flooding, src1 behind them) -> src1_ready = 0; after the next src1 pop, ready = 1 one edge later; no entry lost or duplicated.
REQ-037 Flush: 4 held results plus flush at edge 5 -> out_ROBEN = 0 after edge 6; all ready = 1; a new push at edge 7 is broadcast at edge 8.
REQ-038 Async reset: rst pulled low between edges with queues non-empty -> out_ROBEN = 0 immediately, before any clock edge; ROBEN=0 push -> no broadcast.
